// File: rtl/door_cmd_arbiter.sv
// Purpose : merges wall-panel, remote and auto-close requests into one-cycle
//           buttonup/buttondown commands for the garage-door FSM.
// Latency : request edge sampled at clock k -> command pulse in cycle k+1.
// Backpress: none; losing or blocked requests are dropped, never queued.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   wall_up, wall_down              wall-panel buttons (level)
//   remote_toggle                   remote button (level), direction from door state
//   auto_en                         enables the auto-close countdown
//   sensortop, sensorbottom         door fully open / fully closed
//   lightbarrier                    obstruction present, blocks all down requests
//   motorleft, motorright           door moving up / down (from the door FSM)
//   buttonup, buttondown            one-cycle command pulses to the door FSM
//   grant                           source of last command: 00 none, 01 wall, 10 remote, 11 auto
//   autoclose_active                auto-close countdown running
//   busy                            hold-off window after a command
module door_cmd_arbiter #(
  parameter int AUTO_CLOSE_CYCLES = 8,
  parameter int HOLDOFF_CYCLES    = 4,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wall_up,
  input  logic       wall_down,
  input  logic       remote_toggle,
  input  logic       auto_en,
  input  logic       sensortop,
  input  logic       sensorbottom,
  input  logic       lightbarrier,
  input  logic       motorleft,
  input  logic       motorright,
  output logic       buttonup,
  output logic       buttondown,
  output logic [1:0] grant,
  output logic       autoclose_active,
  output logic       busy
);

  localparam logic [1:0] SRC_WALL   = 2'b01;
  localparam logic [1:0] SRC_REMOTE = 2'b10;
  localparam logic [1:0] SRC_AUTO   = 2'b11;

  localparam logic [CNT_W-1:0] AUTO_LOAD = CNT_W'(AUTO_CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] ac_cnt;
  logic             ac_armed;

  // Previous samples of the button inputs, plus a flag that is clear only in
  // the first cycle after reset so a button held through reset release is
  // taken as the reference level rather than as a fresh press.
  logic             wall_up_q;
  logic             wall_down_q;
  logic             remote_q;
  logic             primed;

  // The sensor bottom and downward motor feedback are part of the door
  // interface but do not influence arbitration.
  logic             unused_inputs;
  assign unused_inputs = sensorbottom ^ motorright;

  // ---------------------------------------------------------------------
  // Request generation
  // ---------------------------------------------------------------------
  logic wall_up_edge;
  logic wall_down_edge;
  logic remote_edge;
  logic any_edge;
  logic remote_is_down;
  logic rem_up_req;
  logic rem_dn_req;
  logic ac_cancel;
  logic ac_expire;
  logic up_req;
  logic dn_req;
  logic [1:0] req_src;

  always_comb begin
    wall_up_edge   = primed & wall_up       & ~wall_up_q;
    wall_down_edge = primed & wall_down     & ~wall_down_q;
    remote_edge    = primed & remote_toggle & ~remote_q;
    any_edge       = wall_up_edge | wall_down_edge | remote_edge;

    // Remote closes an open or opening door, otherwise opens it.
    remote_is_down = sensortop | motorleft;
    rem_up_req     = remote_edge & ~remote_is_down;
    rem_dn_req     = remote_edge &  remote_is_down;

    // Any manual activity or unsafe/unsuitable condition aborts auto-close.
    ac_cancel      = ~sensortop | ~auto_en | lightbarrier | any_edge;
    ac_expire      = autoclose_active & (ac_cnt == '0) & ~ac_cancel;

    up_req         = wall_up_edge | rem_up_req;
    dn_req         = ~lightbarrier & (wall_down_edge | rem_dn_req | ac_expire);

    // Ups are listed first so they win; within a direction wall > remote > auto.
    if (wall_up_edge)        req_src = SRC_WALL;
    else if (rem_up_req)     req_src = SRC_REMOTE;
    else if (wall_down_edge) req_src = SRC_WALL;
    else if (rem_dn_req)     req_src = SRC_REMOTE;
    else                     req_src = SRC_AUTO;
  end

  // ---------------------------------------------------------------------
  // Edge-detect registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wall_up_q   <= 1'b0;
      wall_down_q <= 1'b0;
      remote_q    <= 1'b0;
      primed      <= 1'b0;
    end else begin
      wall_up_q   <= wall_up;
      wall_down_q <= wall_down;
      remote_q    <= remote_toggle;
      primed      <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Auto-close countdown
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_cnt           <= '0;
      autoclose_active <= 1'b0;
      ac_armed         <= 1'b1;
    end else begin
      if (autoclose_active) begin
        if (ac_cancel) begin
          autoclose_active <= 1'b0;
        end else if (ac_cnt == '0) begin
          // Fire once; stay disarmed until the door has left the top.
          autoclose_active <= 1'b0;
          ac_armed         <= 1'b0;
        end else begin
          ac_cnt <= ac_cnt - 1'b1;
        end
      end else if (ac_armed && sensortop && auto_en && !lightbarrier && !any_edge) begin
        // Load is gated by the cancel conditions too, so a held barrier keeps
        // the count from starting and it restarts in full once it clears.
        ac_cnt           <= AUTO_LOAD;
        autoclose_active <= 1'b1;
      end

      if (!sensortop) begin
        ac_armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Command sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      buttonup   <= 1'b0;
      buttondown <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      buttonup   <= 1'b0;
      buttondown <= 1'b0;

      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (up_req || dn_req) begin
            state      <= ST_ISSUE;
            buttonup   <= up_req;
            buttondown <= ~up_req;
            grant      <= req_src;
          end
        end

        ST_ISSUE: begin
          // Requests arriving in the command cycle itself are dropped.
          state    <= ST_HOLD;
          hold_cnt <= HOLD_LOAD;
          busy     <= 1'b1;
        end

        ST_HOLD: begin
          if (up_req) begin
            // Safety reversal: an up request preempts the hold-off window.
            state    <= ST_ISSUE;
            buttonup <= 1'b1;
            grant    <= req_src;
            busy     <= 1'b0;
          end else if (hold_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/door_cmd_arbiter.md
# door_cmd_arbiter

Command arbiter placed in front of the garage-door FSM. It merges requests from the wall panel, a radio remote and an internal auto-close timer into single-cycle `buttonup`/`buttondown` commands. It enforces priority, safety lockout on the light barrier and a hold-off window after each command. Its outputs drive the door FSM's button inputs directly, and it reads back the door's sensors and motor outputs.

## Interface
- `AUTO_CLOSE_CYCLES`, default 8: cycles the door stays open before auto-close fires; must be ≥2.
- `HOLDOFF_CYCLES`, default 4: cycles after a command during which down requests are dropped; must be ≥1.
- `CNT_W`, default 16: width of the internal counters; must hold both cycle counts.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `wall_up`, input, 1: wall-panel up button, level.
- `wall_down`, input, 1: wall-panel down button, level.
- `remote_toggle`, input, 1: remote button, level.
- `auto_en`, input, 1: enables auto-close.
- `sensortop`, input, 1: door fully open.
- `sensorbottom`, input, 1: door fully closed.
- `lightbarrier`, input, 1: obstruction present.
- `motorleft`, input, 1: door moving up, from the door FSM.
- `motorright`, input, 1: door moving down, from the door FSM.
- `buttonup`, output, 1: one-cycle up command.
- `buttondown`, output, 1: one-cycle down command.
- `grant`, output, 2: source of the last issued command. 00 none, 01 wall, 10 remote, 11 auto.
- `autoclose_active`, output, 1: auto-close countdown is running.
- `busy`, output, 1: hold-off window is active.

## Operation
- **Edge detection.** `wall_up`, `wall_down` and `remote_toggle` are registered. A request exists only in the cycle where the current sample is 1 and the previous sample was 0. Held buttons never repeat.
- **Remote translation.** A remote edge becomes a down request if `sensortop` or `motorleft` is high. Otherwise it becomes an up request.
- **Auto-close request.** The auto source raises a down request when its countdown expires (see below).
- **Safety.**
  - While `lightbarrier` is 1, every down request is dropped.
  - Up requests are never blocked.
- **Priority within a cycle.**
  - Up requests beat down requests.
  - Among requests of the same direction: wall > remote > auto.
  - Requests that lose arbitration are dropped, not queued.
- **State machine:** IDLE, ISSUE, HOLD.
  - IDLE: on any surviving request → ISSUE. The chosen direction and source are latched.
  - ISSUE (1 cycle): the latched `buttonup` or `buttondown` is 1 and `grant` updates. → HOLD.
  - HOLD: the hold-off counter runs for HOLDOFF_CYCLES cycles with `busy`=1.
    - A surviving up request → ISSUE immediately, preempting the hold-off (safety reversal).
    - Down requests are dropped.
    - When the counter expires → IDLE.
  - Illegal state encoding → IDLE.
- **Auto-close counter.**
  - Loads AUTO_CLOSE_CYCLES−1 in the first cycle where `sensortop`=1, `auto_en`=1 and the counter is inactive. `autoclose_active`=1 from the next cycle.
  - Decrements once per cycle.
  - Cancelled (inactive, no request) if any of these occur: `sensortop`=0, `auto_en`=0, `lightbarrier`=1, or any wall/remote edge.
  - After cancellation it reloads only if the load condition is still true on a later cycle. A blocked auto-close therefore restarts the full count once the barrier clears.
  - At count 0 it raises the auto down request for one cycle and goes inactive. It does not rearm until `sensortop` has been seen at 0.
  - If that expiry cycle falls in HOLD, the request is dropped and the counter still goes inactive.

## Timing
- **Reset values:** `buttonup`=0, `buttondown`=0, `grant`=00, `autoclose_active`=0, `busy`=0. State = IDLE, counters = 0, edge registers = 0.
- **Reset mid-operation:** all outputs return to their reset values asynchronously. A button still held at reset release does not generate an edge.
- **Registered outputs.**
  - Request edge sampled at clock k → `buttonup`/`buttondown` high for exactly the cycle after k. `grant` is valid from that same cycle.
  - `busy` is high for the HOLDOFF_CYCLES cycles following the command cycle.
  - `buttonup` and `buttondown` are never high together.
- **Command spacing.** At least HOLDOFF_CYCLES+1 cycles separate two down commands. An up command may follow any command after one cycle.
- **Auto-close latency.** With no cancellation, `buttondown` pulses AUTO_CLOSE_CYCLES+1 cycles after the first cycle `sensortop` was sampled high.

## Test plan
Parameters for all scenarios: AUTO_CLOSE_CYCLES=8, HOLDOFF_CYCLES=4.

1. Reset, then `wall_up` 0→1 held for 10 cycles → exactly one `buttonup` pulse, one cycle after the edge. `grant`=01, `busy`=1 for 4 cycles, no repeat.
2. `wall_down` and `remote_toggle` rise in the same cycle with `sensorbottom`=0, `sensortop`=0 (remote maps to up) → `buttonup`, `grant`=10. No `buttondown`.
3. `buttondown` issued, then `wall_down` again 2 cycles later → dropped. `wall_up` 2 cycles later instead → `buttonup` next cycle, `busy` restarts its 4-cycle window.
4. `auto_en`=1, `sensortop` held high → `autoclose_active` from the next cycle, `buttondown` 9 cycles after the first `sensortop` sample, `grant`=11.
5. Auto-close counting, `lightbarrier`=1 pulsed at count 3 → no `buttondown`. Full 8-cycle count restarts after the barrier clears and then fires.
6. `lightbarrier`=1 with `wall_down` edge → no command, state stays IDLE. Reset asserted during HOLD → `busy`=0 and all outputs 0 immediately.
